// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier for 4-bit signed operands.
// Performs one add/subtract-and-shift step per clock and then presents the 8-bit product with a done pulse.
//
// state | meaning
// IDLE  | waiting for start; operands latched when start is seen
// RUN   | four Booth steps, one per clock, counted by cnt
// DONE  | product valid, done high for one cycle
module booth_seq_mult (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] multiplicand,
  input  logic [3:0] multiplier,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state;
  logic [4:0] a_reg;
  logic [4:0] q_reg;
  logic [4:0] m_reg;
  logic [1:0] cnt;

  logic [4:0] sum;
  logic [4:0] a_next;
  logic [4:0] q_next;

  // A is one bit wider than M so that -M still fits when M = -8
  always_comb begin
    sum = a_reg;
    case (q_reg[1:0])
      2'b01:   sum = a_reg + m_reg;
      2'b10:   sum = a_reg + ~m_reg + 5'd1;
      default: sum = a_reg;
    endcase
    a_next = {sum[4], sum[4:1]};
    q_next = {sum[0], q_reg[4:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      a_reg   <= 5'd0;
      q_reg   <= 5'd0;
      m_reg   <= 5'd0;
      cnt     <= 2'd0;
      product <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= 5'd0;
            q_reg <= {multiplier, 1'b0};
            m_reg <= {multiplicand[3], multiplicand};
            cnt   <= 2'd0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          a_reg <= a_next;
          q_reg <= q_next;
          cnt   <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            product <= {a_next[3:0], q_next[4:1]};
            state   <= DONE;
            done    <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed and exhaustive checks for booth_seq_mult: reset, latency, corner operands,
// ignored start requests, mid-run reset and back-to-back throughput.
module tb_booth_seq_mult;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] multiplicand = 4'd0;
  logic [3:0] multiplier = 4'd0;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int errors = 0;
  int checks = 0;

  booth_seq_mult dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full transaction with per-cycle checks of the done timing
  task automatic do_mult(input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp, input string tag);
    @(negedge clk);
    start = 1'b1;
    multiplicand = m;
    multiplier = q;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy@E0"}, busy, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check({tag, " done early"}, done, 1'b0);
    end
    @(posedge clk); #1;
    check({tag, " done@E4"}, done, 1'b1);
    check({tag, " product"}, product, exp);
    @(posedge clk); #1;
    check({tag, " done@E5"}, done, 1'b0);
    check({tag, " busy@E5"}, busy, 1'b0);
    check({tag, " product hold"}, product, exp);
  endtask

  initial begin
    // reset then idle
    #2 reset = 1'b1;
    #1;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst product", product, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("idle outputs", {busy, done, product}, 10'd0);
    end

    // basic values
    do_mult(4'd3, 4'd5, 8'h0F, "3*5");
    do_mult(4'hD, 4'd5, 8'hF1, "-3*5");
    do_mult(4'd7, 4'h8, 8'hC8, "7*-8");

    // corner operands
    do_mult(4'h8, 4'h8, 8'h40, "-8*-8");
    do_mult(4'd0, 4'h8, 8'h00, "0*-8");
    do_mult(4'hF, 4'hF, 8'h01, "-1*-1");
    do_mult(4'd7, 4'd7, 8'h31, "7*7");

    // start requests during RUN and DONE are ignored: 5*(-2) = -10
    @(negedge clk);
    start = 1'b1;
    multiplicand = 4'd5;
    multiplier = 4'hE;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    multiplicand = 4'd7;
    multiplier = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("ign done@E3", done, 1'b0);
    @(posedge clk); #1;
    check("ign done@E4", done, 1'b1);
    check("ign product", product, 8'hF6);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ign busy@E5", busy, 1'b0);
    check("ign done@E5", done, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("ign no extra", {busy, done}, 2'b00);
    end
    check("ign product hold", product, 8'hF6);

    // mid-run reset after E2
    @(negedge clk);
    start = 1'b1;
    multiplicand = 4'd5;
    multiplier = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 1'b0);
    check("midrst product", product, 8'h00);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("midrst no done", {busy, done}, 2'b00);
    end
    do_mult(4'd2, 4'd3, 8'h06, "2*3");

    // exhaustive with start held high: one result per 6 cycles
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0]        iv;
      logic signed [3:0] ms;
      logic signed [3:0] qs;
      int                p;
      logic [7:0]        exp;
      iv = i[7:0];
      ms = iv[7:4];
      qs = iv[3:0];
      p = int'(ms) * int'(qs);
      exp = p[7:0];
      multiplicand = iv[7:4];
      multiplier = iv[3:0];
      @(posedge clk); #1;
      check("exh accept", busy, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check("exh done early", done, 1'b0);
      @(posedge clk); #1;
      check("exh done", done, 1'b1);
      check("exh product", product, exp);
      @(posedge clk); #1;
      check("exh done drop", {busy, done}, 2'b00);
    end
    start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
